// File: rtl/residual_history_store_if.sv
// Bundle of the write, read, swap and norm-status signals of the residual
// history store. Signal suffixes are seen from the store's side.
interface residual_history_store_if #(
  parameter int no_of_units   = 8,
  parameter int element_width = 32,
  parameter int addr_width    = 7,
  parameter int acc_width     = 80
);
  localparam int CW = no_of_units * element_width;

  logic                  wr_en_i;
  logic [addr_width-1:0] wr_addr_i;
  logic [CW-1:0]         wr_re_i;
  logic [CW-1:0]         wr_im_i;
  logic                  rd_en_i;
  logic [addr_width-1:0] rd_addr_i;
  logic [CW-1:0]         rd_re_o;
  logic [CW-1:0]         rd_im_o;
  logic                  rd_valid_o;
  logic                  swap_i;
  logic [acc_width-1:0]  norm_cur_o;
  logic [acc_width-1:0]  norm_prev_o;
  logic                  norm_valid_o;
  logic                  hist_valid_o;
  logic                  swap_error_o;
  logic [15:0]           iter_count_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_re_i, wr_im_i, rd_en_i, rd_addr_i, swap_i,
    input  rd_re_o, rd_im_o, rd_valid_o, norm_cur_o, norm_prev_o,
           norm_valid_o, hist_valid_o, swap_error_o, iter_count_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_re_i, wr_im_i, rd_en_i, rd_addr_i, swap_i,
    output rd_re_o, rd_im_o, rd_valid_o, norm_cur_o, norm_prev_o,
           norm_valid_o, hist_valid_o, swap_error_o, iter_count_o
  );
endinterface

// File: rtl/residual_history_store.sv
// Double-banked complex residual store. One bank takes the current
// iteration's chunks while the other serves the previous iteration to the
// ALU; the squared norm of the chunks being written is accumulated on the fly
// so rho_new/rho_old are ready at each iteration boundary.
module residual_history_store #(
  parameter int no_of_units   = 8,
  parameter int element_width = 32,
  parameter int depth         = 96,
  parameter int addr_width    = 7,
  parameter int acc_width     = 80
) (
  input  logic                    clk,
  input  logic                    reset,
  residual_history_store_if.slave bus
);
  localparam int CW    = no_of_units * element_width;
  localparam int CNT_W = 32;
  localparam logic [addr_width:0] DEPTH_A = depth[addr_width:0];
  localparam logic [CNT_W-1:0]    DEPTH_C = depth[CNT_W-1:0];

  // Square of one signed element, zero-extended to the accumulator width.
  // The square is non-negative, so its 2*element_width bits read as unsigned.
  function automatic logic [acc_width-1:0] sq_ext(input logic signed [element_width-1:0] x);
    logic signed [2*element_width-1:0] p;
    p = x * x;
    return acc_width'($unsigned(p));
  endfunction

  // Storage: bank index first, then chunk address. Data arrays carry no reset.
  logic [CW-1:0] mem_re_q [0:1][0:depth-1];
  logic [CW-1:0] mem_im_q [0:1][0:depth-1];

  logic                 cur_bank_q,   cur_bank_d;
  logic [acc_width-1:0] acc_q,        acc_d;
  logic [CNT_W-1:0]     wr_count_q,   wr_count_d;
  logic                 rd_valid_q,   rd_valid_d;
  logic [CW-1:0]        rd_re_q,      rd_re_d;
  logic [CW-1:0]        rd_im_q,      rd_im_d;
  logic [acc_width-1:0] norm_cur_q,   norm_cur_d;
  logic [acc_width-1:0] norm_prev_q,  norm_prev_d;
  logic                 norm_valid_q, norm_valid_d;
  logic                 hist_valid_q, hist_valid_d;
  logic                 swap_error_q, swap_error_d;
  logic [15:0]          iter_count_q, iter_count_d;

  logic                 wr_ok;
  logic                 rd_hit;
  logic [acc_width-1:0] term;
  logic [CNT_W-1:0]     final_count;

  assign wr_ok  = bus.wr_en_i && ({1'b0, bus.wr_addr_i} < DEPTH_A);
  assign rd_hit = hist_valid_q && ({1'b0, bus.rd_addr_i} < DEPTH_A);
  assign final_count = wr_count_q + CNT_W'(wr_ok);

  // Norm contribution of this cycle's chunk: 2*no_of_units squares summed.
  always_comb begin
    term = '0;
    if (wr_ok) begin
      for (int i = 0; i < no_of_units; i++) begin
        term = term + sq_ext(bus.wr_re_i[i*element_width +: element_width])
                    + sq_ext(bus.wr_im_i[i*element_width +: element_width]);
      end
    end
  end

  // Next-state for read port, accumulator, bank select and norm bookkeeping.
  always_comb begin
    cur_bank_d   = cur_bank_q;
    acc_d        = acc_q + term;
    wr_count_d   = final_count;
    rd_valid_d   = bus.rd_en_i;
    rd_re_d      = rd_re_q;
    rd_im_d      = rd_im_q;
    norm_cur_d   = norm_cur_q;
    norm_prev_d  = norm_prev_q;
    norm_valid_d = bus.swap_i;
    hist_valid_d = hist_valid_q;
    swap_error_d = swap_error_q;
    iter_count_d = iter_count_q;

    // Reads use the bank selected before any swap in this cycle; stale or
    // out-of-range chunks read as zero.
    if (bus.rd_en_i) begin
      rd_re_d = rd_hit ? mem_re_q[~cur_bank_q][bus.rd_addr_i] : '0;
      rd_im_d = rd_hit ? mem_im_q[~cur_bank_q][bus.rd_addr_i] : '0;
    end

    // Iteration boundary: the swap-cycle write still belongs to the old iteration.
    if (bus.swap_i) begin
      cur_bank_d   = ~cur_bank_q;
      norm_prev_d  = norm_cur_q;
      norm_cur_d   = acc_q + term;
      acc_d        = '0;
      wr_count_d   = '0;
      hist_valid_d = 1'b1;
      iter_count_d = iter_count_q + 16'd1;
      if (final_count != DEPTH_C) swap_error_d = 1'b1;
    end
  end

  // Control and read-port registers; reset overrides a coincident swap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_bank_q   <= 1'b0;
      acc_q        <= '0;
      wr_count_q   <= '0;
      rd_valid_q   <= 1'b0;
      rd_re_q      <= '0;
      rd_im_q      <= '0;
      norm_cur_q   <= '0;
      norm_prev_q  <= '0;
      norm_valid_q <= 1'b0;
      hist_valid_q <= 1'b0;
      swap_error_q <= 1'b0;
      iter_count_q <= '0;
    end else begin
      cur_bank_q   <= cur_bank_d;
      acc_q        <= acc_d;
      wr_count_q   <= wr_count_d;
      rd_valid_q   <= rd_valid_d;
      rd_re_q      <= rd_re_d;
      rd_im_q      <= rd_im_d;
      norm_cur_q   <= norm_cur_d;
      norm_prev_q  <= norm_prev_d;
      norm_valid_q <= norm_valid_d;
      hist_valid_q <= hist_valid_d;
      swap_error_q <= swap_error_d;
      iter_count_q <= iter_count_d;
    end
  end

  // Chunk write into the current bank; bank contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_re_q[cur_bank_q][bus.wr_addr_i] <= bus.wr_re_i;
      mem_im_q[cur_bank_q][bus.wr_addr_i] <= bus.wr_im_i;
    end
  end

  assign bus.rd_re_o      = rd_re_q;
  assign bus.rd_im_o      = rd_im_q;
  assign bus.rd_valid_o   = rd_valid_q;
  assign bus.norm_cur_o   = norm_cur_q;
  assign bus.norm_prev_o  = norm_prev_q;
  assign bus.norm_valid_o = norm_valid_q;
  assign bus.hist_valid_o = hist_valid_q;
  assign bus.swap_error_o = swap_error_q;
  assign bus.iter_count_o = iter_count_q;
endmodule

// File: tb/tb_residual_history_store.sv
// Directed bench for residual_history_store: read expectations go into a
// scoreboard queue at issue and are checked when rd_valid comes back.
module tb_residual_history_store;
  localparam int U   = 8;
  localparam int W   = 32;
  localparam int D   = 96;
  localparam int AW  = 7;
  localparam int ACC = 80;
  localparam int CW  = U * W;

  typedef struct {
    logic [CW-1:0] re;
    logic [CW-1:0] im;
  } rd_exp_t;

  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  rd_exp_t sbq[$];

  residual_history_store_if #(.no_of_units(U), .element_width(W),
                              .addr_width(AW), .acc_width(ACC)) bus ();

  residual_history_store #(.no_of_units(U), .element_width(W), .depth(D),
                           .addr_width(AW), .acc_width(ACC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] rep(input logic signed [W-1:0] v);
    logic [CW-1:0] r;
    for (int i = 0; i < U; i++) r[i*W +: W] = v;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic issue_read(input int addr, input logic [CW-1:0] re, input logic [CW-1:0] im);
    rd_exp_t e;
    bus.rd_en_i   = 1'b1;
    bus.rd_addr_i = AW'(addr);
    e.re = re;
    e.im = im;
    sbq.push_back(e);
  endtask

  // One clock with the inputs currently driven; checks any returning read.
  task automatic step();
    logic exp_v;
    rd_exp_t e;
    exp_v = bus.rd_en_i && !reset;
    @(posedge clk);
    #1;
    chk("rd_valid", CW'(bus.rd_valid_o), CW'(exp_v));
    if (bus.rd_valid_o) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("rd_re", bus.rd_re_o, e.re);
        chk("rd_im", bus.rd_im_o, e.im);
      end
    end
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.swap_i  = 1'b0;
  endtask

  // Writes addresses first..last with uniform lanes, swap on the last write;
  // optionally issues one read at write index rd_at.
  task automatic run_iter(input logic signed [W-1:0] re, input logic signed [W-1:0] im,
                          input int first, input int last, input int rd_at, input int rd_a,
                          input logic [CW-1:0] ere, input logic [CW-1:0] eim);
    for (int a = first; a <= last; a++) begin
      bus.wr_en_i   = 1'b1;
      bus.wr_addr_i = AW'(a);
      bus.wr_re_i   = rep(re);
      bus.wr_im_i   = rep(im);
      bus.swap_i    = (a == last);
      if (a == rd_at) issue_read(rd_a, ere, eim);
      step();
    end
  endtask

  task automatic chk_status(input string tag, input int ncur, input int nprev, input logic nv,
                            input logic err, input int iter, input logic hv);
    chk({tag, "_norm_cur"},   CW'(bus.norm_cur_o),   CW'(ncur));
    chk({tag, "_norm_prev"},  CW'(bus.norm_prev_o),  CW'(nprev));
    chk({tag, "_norm_valid"}, CW'(bus.norm_valid_o), CW'(nv));
    chk({tag, "_swap_error"}, CW'(bus.swap_error_o), CW'(err));
    chk({tag, "_iter"},       CW'(bus.iter_count_o), CW'(iter));
    chk({tag, "_hist_valid"}, CW'(bus.hist_valid_o), CW'(hv));
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_re_i = '0; bus.wr_im_i = '0;
    bus.rd_en_i = 1'b0; bus.rd_addr_i = '0; bus.swap_i = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk_status("reset", 0, 0, 1'b0, 1'b0, 0, 1'b0);

    // Read before any history exists returns zeros.
    issue_read(0, '0, '0);
    step();

    // Iteration 1: re=1, im=2 -> 96*8*5.
    run_iter(1, 2, 0, D-1, -1, 0, '0, '0);
    chk_status("it1", 3840, 0, 1'b1, 1'b0, 1, 1'b1);
    issue_read(5, rep(1), rep(2));
    step();
    chk("it1_nv_pulse", CW'(bus.norm_valid_o), CW'(0));

    // Iteration 2: re=-3, im=0 -> 96*8*9; concurrent read still sees iteration 1.
    run_iter(-3, 0, 0, D-1, 0, 5, rep(1), rep(2));
    chk_status("it2", 6912, 3840, 1'b1, 1'b0, 2, 1'b1);
    issue_read(5, rep(-3), rep(0));
    step();

    // Iteration 3: dropped write to 100 plus 95 chunks -> count 95, error.
    bus.wr_en_i = 1'b1; bus.wr_addr_i = AW'(100);
    bus.wr_re_i = rep(7); bus.wr_im_i = rep(7);
    step();
    run_iter(5, -1, 0, D-2, -1, 0, '0, '0);
    chk_status("it3", 19760, 6912, 1'b1, 1'b1, 3, 1'b1);
    issue_read(100, '0, '0);
    step();
    issue_read(95, rep(1), rep(2));
    step();

    // Iteration 4 (clean): read 7 in the swap cycle sees iteration 3.
    run_iter(4, 4, 0, D-1, D-1, 7, rep(5), rep(-1));
    chk_status("it4", 24576, 19760, 1'b1, 1'b1, 4, 1'b1);
    issue_read(7, rep(4), rep(4));
    step();

    // Partial write, then reset together with swap: swap discarded.
    bus.wr_en_i = 1'b1; bus.wr_addr_i = AW'(7);
    bus.wr_re_i = rep(9); bus.wr_im_i = rep(9);
    step();
    reset = 1'b1;
    bus.swap_i = 1'b1;
    step();
    reset = 1'b0;
    chk_status("rst_swap", 0, 0, 1'b0, 1'b0, 0, 1'b0);

    // Empty iteration: norm 0, error set; bank contents survived reset.
    bus.swap_i = 1'b1;
    step();
    chk_status("empty", 0, 0, 1'b1, 1'b1, 1, 1'b1);
    issue_read(7, rep(9), rep(9));
    step();

    chk("sb_drained", CW'(sbq.size()), CW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
